// File: rtl/ct_mat_exu_alu_rowseq.sv
// Matrix ALU row sequencer: accepts one instruction, issues sizeM row operations,
// waits EX_LAT cycles and commits. Optional row_stall port under MAT_ALU_ROW_STALL_EN.
module ct_mat_exu_alu_rowseq #(
  parameter int IID_W  = 7,
  parameter int ROW_W  = 8,
  parameter int OP_W   = 11,
  parameter int EX_LAT = 2
) (
  input  logic             ctrl_clk,
  input  logic             cpurst_b,
  input  logic             rtu_yy_xx_flush,
  input  logic             idu_mat_rf_alu_sel,
  input  logic [IID_W-1:0] idu_mat_rf_pipe8_iid,
  input  logic [OP_W-1:0]  idu_mat_rf_pipe8_alu_op,
  input  logic [ROW_W-1:0] x_sizeM,
  output logic             mat_alu_idu_ready,
  output logic             mat_alu_row_vld,
  output logic [ROW_W-1:0] mat_alu_row_idx,
  output logic [OP_W-1:0]  mat_alu_row_op,
  output logic             mat_alu_cbus_pipe8_sel,
  output logic [IID_W-1:0] mat_alu_cbus_pipe8_iid
`ifdef MAT_ALU_ROW_STALL_EN
  ,
  input  logic             row_stall
`endif
);

  // state | meaning
  // IDLE  | ready for a new instruction
  // RUN   | issuing one row per cycle
  // DRAIN | waiting EX_LAT cycles, then commit
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [2:0] LAT_INIT = 3'(EX_LAT);

  state_t           state, state_nxt;
  logic [ROW_W-1:0] row_cnt;
  logic [ROW_W-1:0] size_q;
  logic [IID_W-1:0] iid_q;
  logic [OP_W-1:0]  op_q;
  logic [2:0]       lat_cnt;
  logic             stall;
  logic             accept;
  logic             issue;
  logic             last_row;
  logic             commit;

`ifdef MAT_ALU_ROW_STALL_EN
  assign stall = row_stall;
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    issue     = 1'b0;
    last_row  = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (idu_mat_rf_alu_sel && !rtu_yy_xx_flush) begin
          accept    = 1'b1;
          state_nxt = (x_sizeM != '0) ? RUN : DRAIN;
        end
      end
      RUN: begin
        if (!rtu_yy_xx_flush && !stall) begin
          issue    = 1'b1;
          last_row = (row_cnt == size_q - ROW_W'(1));
          if (last_row) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (!rtu_yy_xx_flush && !stall && lat_cnt == 3'd0) begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (rtu_yy_xx_flush) state_nxt = IDLE;
  end

  always_ff @(posedge ctrl_clk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state   <= IDLE;
      row_cnt <= '0;
      size_q  <= '0;
      iid_q   <= '0;
      op_q    <= '0;
      lat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (rtu_yy_xx_flush) begin
        row_cnt <= '0;
      end else if (accept) begin
        iid_q   <= idu_mat_rf_pipe8_iid;
        op_q    <= idu_mat_rf_pipe8_alu_op;
        size_q  <= x_sizeM;
        row_cnt <= '0;
      end else if (issue && !last_row) begin
        row_cnt <= row_cnt + ROW_W'(1);
      end else if (commit) begin
        row_cnt <= '0;
      end
      // Latency timer loads on DRAIN entry and counts down to the commit cycle
      if (state_nxt == DRAIN && state != DRAIN) begin
        lat_cnt <= LAT_INIT;
      end else if (state == DRAIN && !stall && lat_cnt != 3'd0) begin
        lat_cnt <= lat_cnt - 3'd1;
      end
    end
  end

  assign mat_alu_idu_ready      = (state == IDLE);
  assign mat_alu_row_vld        = issue;
  assign mat_alu_row_idx        = row_cnt;
  assign mat_alu_row_op         = (state != IDLE) ? op_q : '0;
  assign mat_alu_cbus_pipe8_sel = commit;
  assign mat_alu_cbus_pipe8_iid = iid_q;

endmodule

// File: tb/tb_ct_mat_exu_alu_rowseq.sv
// Directed bench for ct_mat_exu_alu_rowseq (EX_LAT=2); stall steps run only
// when MAT_ALU_ROW_STALL_EN is defined.
module tb_ct_mat_exu_alu_rowseq;
  logic        ctrl_clk = 1'b0;
  logic        cpurst_b;
  logic        flush;
  logic        sel;
  logic [6:0]  iid;
  logic [10:0] op;
  logic [7:0]  size_m;
  logic        ready;
  logic        row_vld;
  logic [7:0]  row_idx;
  logic [10:0] row_op;
  logic        cbus_sel;
  logic [6:0]  cbus_iid;
`ifdef MAT_ALU_ROW_STALL_EN
  logic        stall;
`endif

  int checks = 0;
  int errors = 0;

  always #5 ctrl_clk = ~ctrl_clk;

  ct_mat_exu_alu_rowseq #(.IID_W(7), .ROW_W(8), .OP_W(11), .EX_LAT(2)) dut (
    .ctrl_clk               (ctrl_clk),
    .cpurst_b               (cpurst_b),
    .rtu_yy_xx_flush        (flush),
    .idu_mat_rf_alu_sel     (sel),
    .idu_mat_rf_pipe8_iid   (iid),
    .idu_mat_rf_pipe8_alu_op(op),
    .x_sizeM                (size_m),
    .mat_alu_idu_ready      (ready),
    .mat_alu_row_vld        (row_vld),
    .mat_alu_row_idx        (row_idx),
    .mat_alu_row_op         (row_op),
    .mat_alu_cbus_pipe8_sel (cbus_sel),
    .mat_alu_cbus_pipe8_iid (cbus_iid)
`ifdef MAT_ALU_ROW_STALL_EN
    ,
    .row_stall              (stall)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic cyc();
    @(posedge ctrl_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int commits, bad, issues, last, c1, c2;
    logic [6:0] i1, i2;
    cpurst_b = 1'b0; flush = 1'b0; sel = 1'b0; iid = '0; op = '0; size_m = '0;
`ifdef MAT_ALU_ROW_STALL_EN
    stall = 1'b0;
`endif
    #12;
    chk("rst_ready", ready, 1);
    chk("rst_row_vld", row_vld, 0);
    chk("rst_row_idx", row_idx, 0);
    chk("rst_row_op", row_op, 0);
    chk("rst_cbus_sel", cbus_sel, 0);
    chk("rst_cbus_iid", cbus_iid, 0);
    cyc();
    cpurst_b = 1'b1;
    cyc();

    // basic run: sizeM=4, iid=0x15, commit sampled 7 edges after accept
    sel = 1'b1; iid = 7'h15; op = 11'h004; size_m = 8'd4;
    #2 chk("basic_ready_pre", ready, 1);
    cyc();
    sel = 1'b0; iid = 7'h00; op = 11'h000; size_m = 8'd0;
    for (int k = 0; k < 4; k++) begin
      #2;
      chk("basic_vld", row_vld, 1);
      chk("basic_idx", row_idx, k);
      chk("basic_op", row_op, 11'h004);
      chk("basic_ready_busy", ready, 0);
      cyc();
    end
    for (int k = 0; k < 2; k++) begin
      #2;
      chk("basic_drain_vld", row_vld, 0);
      chk("basic_drain_sel", cbus_sel, 0);
      cyc();
    end
    #2;
    chk("basic_commit_sel", cbus_sel, 1);
    chk("basic_commit_iid", cbus_iid, 7'h15);
    cyc();
    #2;
    chk("basic_post_sel", cbus_sel, 0);
    chk("basic_post_ready", ready, 1);
    chk("basic_post_op", row_op, 0);
    cyc();

    // zero size: no rows, commit 3 edges after accept
    sel = 1'b1; iid = 7'h03; op = 11'h001; size_m = 8'd0;
    cyc();
    sel = 1'b0;
    bad = 0;
    for (int k = 0; k < 2; k++) begin
      #2;
      if (row_vld !== 1'b0 || cbus_sel !== 1'b0) bad++;
      cyc();
    end
    chk("zero_quiet", bad, 0);
    #2;
    chk("zero_commit_sel", cbus_sel, 1);
    chk("zero_commit_iid", cbus_iid, 7'h03);
    cyc();

    // flush has priority over accept in IDLE
    sel = 1'b1; flush = 1'b1; iid = 7'h2A; op = 11'h010; size_m = 8'd8;
    cyc();
    sel = 1'b0; flush = 1'b0;
    #2 chk("flush_blocks_accept", ready, 1);
    cyc();

    // flush in RUN at row_idx 3
    sel = 1'b1;
    cyc();
    sel = 1'b0;
    for (int k = 0; k < 3; k++) cyc();
    #2 chk("flush_idx_before", row_idx, 3);
    flush = 1'b1;
    #1;
    chk("flush_vld_forced", row_vld, 0);
    cyc();
    flush = 1'b0;
    #2;
    chk("flush_ready", ready, 1);
    chk("flush_row_op", row_op, 0);
    chk("flush_idx_clear", row_idx, 0);
    commits = 0;
    for (int k = 0; k < 15; k++) begin
      if (cbus_sel === 1'b1) commits++;
      cyc();
      #2;
    end
    chk("flush_no_commit", commits, 0);

    // back-to-back with sel held: commits at cycles 4 and 10 after first accept
    sel = 1'b1; iid = 7'h01; op = 11'h020; size_m = 8'd2;
    cyc();
    iid = 7'h02;
    c1 = -1; c2 = -1; i1 = '0; i2 = '0;
    for (int c = 0; c < 12; c++) begin
      if (c == 6) sel = 1'b0;
      #2;
      if (c == 5) chk("b2b_ready_gap", ready, 1);
      if (cbus_sel === 1'b1) begin
        if (c1 < 0) begin c1 = c; i1 = cbus_iid; end
        else begin c2 = c; i2 = cbus_iid; end
      end
      cyc();
    end
    chk("b2b_c1_cycle", c1, 4);
    chk("b2b_c1_iid", i1, 7'h01);
    chk("b2b_c2_cycle", c2, 10);
    chk("b2b_c2_iid", i2, 7'h02);

    // maximum size 255
    sel = 1'b1; iid = 7'h7F; op = 11'h400; size_m = 8'd255;
    cyc();
    sel = 1'b0;
    issues = 0; last = 0; bad = 0;
    for (int k = 0; k < 255; k++) begin
      #2;
      if (row_vld === 1'b1) begin
        if (row_idx !== 8'(k)) bad++;
        issues++;
        last = int'(row_idx);
      end
      cyc();
    end
    chk("max_issues", issues, 255);
    chk("max_last_idx", last, 8'hFE);
    chk("max_seq", bad, 0);
    #2 chk("max_drain_idx", row_idx, 8'hFE);
    cyc();
    cyc();
    #2;
    chk("max_commit_sel", cbus_sel, 1);
    chk("max_commit_iid", cbus_iid, 7'h7F);
    cyc();

    // reset mid-operation abandons the instruction
    sel = 1'b1; iid = 7'h33; op = 11'h008; size_m = 8'd5;
    cyc();
    sel = 1'b0;
    cyc();
    cpurst_b = 1'b0;
    #1;
    chk("midrst_ready", ready, 1);
    chk("midrst_vld", row_vld, 0);
    chk("midrst_iid", cbus_iid, 0);
    cyc();
    cpurst_b = 1'b1;
    commits = 0;
    for (int k = 0; k < 12; k++) begin
      #2;
      if (cbus_sel === 1'b1) commits++;
      cyc();
    end
    chk("midrst_no_commit", commits, 0);

`ifdef MAT_ALU_ROW_STALL_EN
    // stall 2 cycles at row_idx 1: commit sampled 8 edges after accept
    sel = 1'b1; iid = 7'h11; op = 11'h002; size_m = 8'd3;
    cyc();
    sel = 1'b0;
    #2 chk("stall_idx0", row_idx, 0);
    cyc();
    stall = 1'b1;
    #2;
    chk("stall_vld_a", row_vld, 0);
    chk("stall_idx_a", row_idx, 1);
    cyc();
    #2;
    chk("stall_vld_b", row_vld, 0);
    chk("stall_idx_b", row_idx, 1);
    cyc();
    stall = 1'b0;
    #2;
    chk("stall_vld_c", row_vld, 1);
    chk("stall_idx_c", row_idx, 1);
    cyc();
    #2 chk("stall_idx2", row_idx, 2);
    cyc();
    cyc();
    cyc();
    #2;
    chk("stall_commit_sel", cbus_sel, 1);
    chk("stall_commit_iid", cbus_iid, 7'h11);
    cyc();
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
